// File: rtl/shifter_scheduler_if.sv
// Bundle between the shifter scheduler, its two requesters, the shared
// barrel shifter and the response consumer.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens on the rising clock edge where valid and ready are both high;
// the source keeps valid and its payload stable until that edge, and the
// sink keeps its outputs stable while it holds valid without ready.
interface shifter_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_sel;
    logic [31:0] req0_shiftee;
    logic [31:0] req0_shifter;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_sel;
    logic [31:0] req1_shiftee;
    logic [31:0] req1_shifter;

    logic        c_flag;

    logic [3:0]  bs_sel;
    logic [31:0] bs_shiftee;
    logic [31:0] bs_shifter;
    logic        bs_c_flag;
    logic [31:0] bs_operand;
    logic [31:0] bs_carry;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_operand;
    logic        rsp_carry;
    logic        rsp_err;

    // Environment side: requesters, shifter datapath and response consumer.
    modport master (
        output req0_valid, req0_sel, req0_shiftee, req0_shifter,
        input  req0_ready,
        output req1_valid, req1_sel, req1_shiftee, req1_shifter,
        input  req1_ready,
        output c_flag,
        input  bs_sel, bs_shiftee, bs_shifter, bs_c_flag,
        output bs_operand, bs_carry,
        input  rsp_valid, rsp_id, rsp_operand, rsp_carry, rsp_err,
        output rsp_ready
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_sel, req0_shiftee, req0_shifter,
        output req0_ready,
        input  req1_valid, req1_sel, req1_shiftee, req1_shifter,
        output req1_ready,
        input  c_flag,
        output bs_sel, bs_shiftee, bs_shifter, bs_c_flag,
        input  bs_operand, bs_carry,
        output rsp_valid, rsp_id, rsp_operand, rsp_carry, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/shifter_scheduler.sv
// Round-robin sequencer for the single shared barrel shifter. Accepts one
// operation at a time from port 0 (operand 2) or port 1 (load/store offset),
// drives the shifter from registers, inserts the Rs-read stall for
// register-specified shifts and holds the result in a response register.
module shifter_scheduler (
    input  logic               clk,
    input  logic               reset,
    shifter_scheduler_if.slave bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSWAIT = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        last;
    logic        err_q;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        acc_id;
    logic [3:0]  acc_sel;
    logic [31:0] acc_shiftee;
    logic [31:0] acc_shifter;
    logic        acc_illegal;
    logic        acc_is_reg;
    logic [31:0] acc_amount;

    // Only bit 0 of the shifter carry bus carries information.
    logic        unused_carry_bits;
    assign unused_carry_bits = ^bus.bs_carry[31:1];

    assign dbg_state = state;

    // Arbitration, acceptance strobes and shift-amount masking of the winner.
    always_comb begin
        // On a tie the port that did not win last time goes first.
        grant0 = bus.req0_valid & (~bus.req1_valid | last);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last);

        bus.req0_ready = (state == IDLE) & ~reset & grant0;
        bus.req1_ready = (state == IDLE) & ~reset & grant1;

        accept = bus.req0_ready | bus.req1_ready;
        acc_id = bus.req1_ready;

        acc_sel     = acc_id ? bus.req1_sel     : bus.req0_sel;
        acc_shiftee = acc_id ? bus.req1_shiftee : bus.req0_shiftee;
        acc_shifter = acc_id ? bus.req1_shifter : bus.req0_shifter;

        // Odd codes with bit 3 set have no shifter meaning.
        acc_illegal = acc_sel[3] & acc_sel[0];
        acc_is_reg  = acc_sel[0] & ~acc_sel[3];

        acc_amount = 32'd0;
        if (acc_sel == 4'b1000) begin
            acc_amount = {28'd0, acc_shifter[3:0]};
        end else if (!acc_sel[0]) begin
            acc_amount = {27'd0, acc_shifter[4:0]};
        end else if (acc_is_reg) begin
            acc_amount = {24'd0, acc_shifter[7:0]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: register forms take one extra cycle for the Rs read.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = acc_is_reg ? RSWAIT : EXEC;
                end
            end
            RSWAIT: state_nx = EXEC;
            EXEC:   state_nx = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shifter drive registers, round-robin pointer and error bit, loaded only on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bs_sel     <= 4'd0;
            bus.bs_shiftee <= 32'd0;
            bus.bs_shifter <= 32'd0;
            bus.bs_c_flag  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            last           <= 1'b1;
            err_q          <= 1'b0;
        end else if (accept) begin
            // An illegal code becomes LSL #0, which passes shiftee through with carry = C.
            bus.bs_sel     <= acc_illegal ? 4'd0 : acc_sel;
            bus.bs_shiftee <= acc_shiftee;
            bus.bs_shifter <= acc_amount;
            bus.bs_c_flag  <= bus.c_flag;
            bus.rsp_id     <= acc_id;
            last           <= acc_id;
            err_q          <= acc_illegal;
        end
    end

    // Response register: captures the shifter output at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_operand <= 32'd0;
            bus.rsp_carry   <= 1'b0;
            bus.rsp_err     <= 1'b0;
        end else if (state == EXEC) begin
            bus.rsp_operand <= bus.bs_operand;
            bus.rsp_carry   <= bus.bs_carry[0];
            bus.rsp_err     <= err_q;
        end
    end

    assign bus.rsp_valid = (state == RESP);

endmodule

// File: tb/tb_shifter_scheduler.sv
// Self-checking bench for shifter_scheduler: directed scenarios plus a
// randomized two-port phase, with a behavioural barrel shifter on the bs_* bus.
module tb_shifter_scheduler;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RSWAIT = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    shifter_scheduler_if bus();

    shifter_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------- barrel shifter model
    function automatic logic [32:0] bs_model(input logic [3:0] sel, input logic [31:0] rm,
                                             input logic [31:0] s, input logic c);
        int          k;
        int          j;
        logic [31:0] res;
        logic        co;
        res = rm;
        co  = c;
        casez (sel)
            4'b1000: begin
                k = 2 * int'(s[3:0]);
                if (k != 0) begin
                    res = (rm >> k) | (rm << (32 - k));
                    co  = res[31];
                end
            end
            4'b?000: begin
                k = int'(s[4:0]);
                if (k != 0) begin res = rm << k; co = rm[32 - k]; end
            end
            4'b0001: begin
                k = int'(s[7:0]);
                if (k == 0) begin end
                else if (k < 32) begin res = rm << k; co = rm[32 - k]; end
                else if (k == 32) begin res = 32'd0; co = rm[0]; end
                else begin res = 32'd0; co = 1'b0; end
            end
            4'b?010: begin
                k = int'(s[4:0]);
                if (k == 0) begin res = 32'd0; co = rm[31]; end
                else begin res = rm >> k; co = rm[k - 1]; end
            end
            4'b0011: begin
                k = int'(s[7:0]);
                if (k == 0) begin end
                else if (k < 32) begin res = rm >> k; co = rm[k - 1]; end
                else if (k == 32) begin res = 32'd0; co = rm[31]; end
                else begin res = 32'd0; co = 1'b0; end
            end
            4'b?100: begin
                k = int'(s[4:0]);
                if (k == 0) begin res = {32{rm[31]}}; co = rm[31]; end
                else begin res = $signed(rm) >>> k; co = rm[k - 1]; end
            end
            4'b0101: begin
                k = int'(s[7:0]);
                if (k == 0) begin end
                else if (k < 32) begin res = $signed(rm) >>> k; co = rm[k - 1]; end
                else begin res = {32{rm[31]}}; co = rm[31]; end
            end
            4'b?110: begin
                k = int'(s[4:0]);
                if (k == 0) begin res = {c, rm[31:1]}; co = rm[0]; end
                else begin res = (rm >> k) | (rm << (32 - k)); co = rm[k - 1]; end
            end
            4'b0111: begin
                k = int'(s[7:0]);
                j = k % 32;
                if (k == 0) begin end
                else if (j == 0) begin co = rm[31]; end
                else begin res = (rm >> j) | (rm << (32 - j)); co = rm[j - 1]; end
            end
            default: begin end
        endcase
        return {co, res};
    endfunction

    // Shift amount as the scheduler should present it to the shifter.
    function automatic logic [31:0] mask_amount(input logic [3:0] sel, input logic [31:0] s);
        if (sel == 4'b1000)          return {28'd0, s[3:0]};
        else if (!sel[0])            return {27'd0, s[4:0]};
        else if (!sel[3])            return {24'd0, s[7:0]};
        else                         return 32'd0;
    endfunction

    // The upper carry bits carry noise so that only bit 0 may be trusted.
    logic [32:0] bs_out;
    always_comb bs_out = bs_model(bus.bs_sel, bus.bs_shiftee, bus.bs_shifter, bus.bs_c_flag);
    assign bus.bs_operand = bs_out[31:0];
    assign bus.bs_carry   = {bs_out[30:0], bs_out[32]};

    // ---------------------------------------------- c_flag and rsp_ready drive
    logic c_rand    = 1'b0;
    logic c_fixed   = 1'b0;
    logic rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;

    always @(posedge clk) begin
        #1;
        bus.c_flag    = c_rand ? 1'($urandom_range(0, 1)) : c_fixed;
        bus.rsp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_fixed;
    end

    // ------------------------------------------------------------ scoreboard
    // Entries are {id, err, carry, operand}.
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];
    int          lat_q[$];
    int          acc_cyc_q[$];
    int          grant_log[$];

    logic        pend_ok = 1'b0;
    logic [3:0]  pend_sel;
    logic [31:0] pend_shiftee;
    logic [31:0] pend_shifter;
    logic        pend_c;

    logic        held = 1'b0;
    logic [34:0] held_rsp;

    always @(negedge clk) begin
        logic [3:0]  s_sel;
        logic [31:0] s_rm;
        logic [31:0] s_sh;
        logic        s_id;
        logic        s_ill;
        logic [3:0]  s_eff;
        logic [32:0] s_res;
        logic [34:0] cur;
        if (reset) begin
            if (bus.req0_valid || bus.req1_valid)
                check("ready_in_reset", {bus.req0_ready, bus.req1_ready}, 2'b00);
            exp_q.delete();
            lat_q.delete();
            acc_cyc_q.delete();
            pend_ok = 1'b0;
            held    = 1'b0;
        end else begin
            if (bus.req0_ready || bus.req1_ready) begin
                check("one_ready", bus.req0_ready & bus.req1_ready, 1'b0);
                s_id  = bus.req1_ready;
                s_sel = s_id ? bus.req1_sel     : bus.req0_sel;
                s_rm  = s_id ? bus.req1_shiftee : bus.req0_shiftee;
                s_sh  = s_id ? bus.req1_shifter : bus.req0_shifter;
                s_ill = (s_sel == 4'b1001) || (s_sel == 4'b1011) ||
                        (s_sel == 4'b1101) || (s_sel == 4'b1111);
                s_eff = s_ill ? 4'b0000 : s_sel;
                s_res = bs_model(s_eff, s_rm, mask_amount(s_sel, s_sh), bus.c_flag);
                exp_q.push_back({s_id, s_ill, s_res[32], s_res[31:0]});
                grant_log.push_back(int'(s_id));
                lat_q.push_back((s_sel[0] && !s_sel[3]) ? 3 : 2);
                acc_cyc_q.push_back(cyc);
                pend_ok      = 1'b1;
                pend_sel     = s_eff;
                pend_shiftee = s_rm;
                pend_shifter = mask_amount(s_sel, s_sh);
                pend_c       = bus.c_flag;
            end
            if (dbg_state == S_EXEC && pend_ok) begin
                check("exec_bs_sel_c", {bus.bs_sel, bus.bs_c_flag}, {pend_sel, pend_c});
                check("exec_bs_shiftee", bus.bs_shiftee, pend_shiftee);
                check("exec_bs_shifter", bus.bs_shifter, pend_shifter);
                pend_ok = 1'b0;
            end
            cur = {bus.rsp_id, bus.rsp_err, bus.rsp_carry, bus.rsp_operand};
            if (bus.rsp_valid) begin
                if (held) begin
                    check("rsp_hold", cur, held_rsp);
                end else begin
                    check("rsp_expected", lat_q.size() != 0, 1'b1);
                    if (lat_q.size() != 0)
                        check("rsp_latency", cyc - acc_cyc_q.pop_front(), lat_q.pop_front());
                end
                if (bus.rsp_ready) begin
                    got_q.push_back(cur);
                    check("exp_avail", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("rsp_data", cur, exp_q.pop_front());
                end
            end
            held     = bus.rsp_valid && !bus.rsp_ready;
            held_rsp = cur;
        end
    end

    // ---------------------------------------------------------- driver tasks
    task automatic drive_req(input int port, input logic [3:0] sel,
                             input logic [31:0] rm, input logic [31:0] s);
        int   n;
        logic got;
        @(posedge clk); #1;
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_sel = sel; bus.req0_shiftee = rm; bus.req0_shifter = s;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_sel = sel; bus.req1_shiftee = rm; bus.req1_shifter = s;
        end
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = (port == 0) ? bus.req0_ready : bus.req1_ready;
        end
        check((port == 0) ? "req0_accept" : "req1_accept", got, 1'b1);
        @(posedge clk); #1;
        if (port == 0) begin
            bus.req0_valid = 1'b0; bus.req0_shiftee = $urandom; bus.req0_shifter = $urandom;
        end else begin
            bus.req1_valid = 1'b0; bus.req1_shiftee = $urandom; bus.req1_shifter = $urandom;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dbg_state == S_IDLE && exp_q.size() == 0) && n < 300);
        check("drain", {dbg_state, 8'(exp_q.size())}, {S_IDLE, 8'd0});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick_amount();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd31;
            3: return 32'd32;
            4: return 32'd33;
            5: return 32'h0000_0100;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------- main flow
    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_sel = 4'b0000; bus.req0_shiftee = 32'd5; bus.req0_shifter = 32'd1;
        bus.req1_valid = 1'b1; bus.req1_sel = 4'b0000; bus.req1_shiftee = 32'd6; bus.req1_shifter = 32'd1;

        // Reset values, with both ports requesting during reset.
        @(posedge clk);
        @(negedge clk);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("rst_bs_sel_c", {bus.bs_sel, bus.bs_c_flag}, 5'd0);
        check("rst_bs_shiftee", bus.bs_shiftee, 32'd0);
        check("rst_bs_shifter", bus.bs_shifter, 32'd0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_carry, bus.rsp_operand}, 36'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Tie on the first request: port 0 then port 1.
        grant_log.delete();
        got_q.delete();
        fork
            drive_req(0, 4'b0000, 32'h0000_0001, 32'd4);
            drive_req(1, 4'b0010, 32'h8000_0000, 32'd31);
        join
        wait_idle();
        check("arb_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("arb_first", grant_log[0], 0);
            check("arb_second", grant_log[1], 1);
        end
        if (got_q.size() >= 2) begin
            check("arb_rsp0", got_q[0], {1'b0, 1'b0, 1'b0, 32'h0000_0010});
            check("arb_rsp1", got_q[1], {1'b1, 1'b0, 1'b0, 32'h0000_0001});
        end

        // Register form: Rs stall cycle and 8-bit amount mask.
        got_q.delete();
        drive_req(1, 4'b0101, 32'h8000_0000, 32'hFFFF_FF04);
        @(negedge clk);
        check("reg_state", dbg_state, S_RSWAIT);
        check("reg_bs_sel", bus.bs_sel, 4'b0101);
        check("reg_bs_shifter", bus.bs_shifter, 32'h0000_0004);
        wait_idle();
        if (got_q.size() >= 1) check("reg_rsp", got_q[0], {1'b1, 1'b0, 1'b0, 32'hF800_0000});

        // Illegal selector; C changes after acceptance must not matter.
        got_q.delete();
        c_fixed = 1'b1;
        drive_req(0, 4'b1011, 32'h1234_5678, 32'h0000_001F);
        c_fixed = 1'b0;
        @(negedge clk);
        check("ill_bs_sel", bus.bs_sel, 4'b0000);
        check("ill_bs_shifter", bus.bs_shifter, 32'd0);
        wait_idle();
        if (got_q.size() >= 1) check("ill_rsp", got_q[0], {1'b0, 1'b1, 1'b1, 32'h1234_5678});

        // Response backpressure with port 1 waiting.
        begin
            int   n;
            logic seen;
            rdy_fixed = 1'b0;
            drive_req(0, 4'b0110, 32'h0000_00F1, 32'd4);
            fork
                drive_req(1, 4'b0001, 32'hFFFF_FFFF, 32'd32);
            join_none
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 50) begin
                @(negedge clk);
                n++;
                seen = bus.rsp_valid;
            end
            check("bp_rsp_seen", seen, 1'b1);
            check("bp_req1_wait0", bus.req1_ready, 1'b0);
            for (int i = 1; i < 5; i++) begin
                @(negedge clk);
                check("bp_req1_wait", {bus.rsp_valid, bus.req1_ready}, 2'b10);
            end
            rdy_fixed = 1'b1;
            @(negedge clk);
            check("bp_handshake", {bus.rsp_valid, bus.rsp_ready}, 2'b11);
            @(negedge clk);
            check("bp_req1_next", bus.req1_ready, 1'b1);
            wait fork;
            wait_idle();
        end

        // Round-robin fairness under a continuous tie.
        do_reset();
        grant_log.delete();
        rdy_rand = 1'b1;
        fork
            repeat (3) drive_req(0, 4'($urandom_range(0, 15)), $urandom, pick_amount());
            repeat (3) drive_req(1, 4'($urandom_range(0, 15)), $urandom, pick_amount());
        join
        wait_idle();
        check("rr_count", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            check("rr_order", grant_log[i], i % 2);

        // Reset while waiting for the Rs read.
        rdy_rand = 1'b0;
        drive_req(1, 4'b0111, 32'hDEAD_BEEF, 32'd8);
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_sel = 4'b0100; bus.req0_shiftee = 32'h8000_00F0; bus.req0_shifter = 32'd4;
        bus.req1_valid = 1'b1; bus.req1_sel = 4'b0000; bus.req1_shiftee = 32'h0000_0003; bus.req1_shifter = 32'd2;
        @(negedge clk);
        check("mid_state", dbg_state, S_RSWAIT);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_idle", {dbg_state, bus.rsp_valid}, {S_IDLE, 1'b0});
        check("mid_bs_sel_c", {bus.bs_sel, bus.bs_c_flag}, 5'd0);
        check("mid_bs_data", {bus.bs_shiftee, bus.bs_shifter}, 64'd0);
        check("mid_tie", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("mid_port1_next", bus.req1_ready, 1'b0);
        bus.req1_valid = 1'b0;
        wait_idle();

        // Randomized traffic from both ports with random C and backpressure.
        rdy_rand = 1'b1;
        c_rand   = 1'b1;
        fork
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                drive_req(0, 4'($urandom_range(0, 15)), $urandom, pick_amount());
            end
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                drive_req(1, 4'($urandom_range(0, 15)), $urandom, pick_amount());
            end
        join
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
